bcd_timer_core: RTL and testbench
=================================

// Module: bcd_timer_core
// PURPOSE
//   Two-digit BCD stopwatch/countdown engine producing tens_BCD/digits_BCD for the
//   seven-segment display decoder stage directly downstream. Counts 00->99 (up) or
//   preset->00 (down) at one step per prescaled tick. Controlled by start/pause and
//   clear pulses from the (already debounced, one-pulsed) push-button front end.
// PARAMETERS
//   TICK_DIV  100_000_000  clk cycles per count step (>=2); benches use 4
// PORTS
//   clk            in   1  system clock, all logic on posedge
//   rst_n          in   1  asynchronous, active-low reset
//   start_pause    in   1  single-cycle pulse: start / pause / resume
//   clear          in   1  single-cycle pulse: abort, return to IDLE
//   up_down        in   1  1 = count up from 00, 0 = count down from preset
//   preset_tens    in   4  BCD tens preset for down mode
//   preset_digits  in   4  BCD units preset for down mode
//   tens_BCD       out  4  registered BCD tens digit (0..9)
//   digits_BCD     out  4  registered BCD units digit (0..9)
//   running        out  1  1 while in RUN
//   done           out  1  1 while in DONE (terminal count reached)
// BEHAVIOUR
//   - Reset: state IDLE, tens_BCD=0, digits_BCD=0, running=0, done=0, prescaler=0, dir=up.
//   - Preset clamp: any preset nibble >9 is treated as 9.
//   - IDLE: each cycle digits load 00 (up_down=1) or clamped preset (up_down=0).
//     start_pause -> RUN; up_down latched into dir; prescaler cleared.
//   - RUN: prescaler counts 0..TICK_DIV-1; tick = 1-cycle pulse at TICK_DIV-1.
//     up tick: units+1; units 9->0 carries tens+1. Reaching 99 -> DONE same edge.
//     down tick: units-1; units 0->9 borrows tens-1. Reaching 00 -> DONE same edge.
//     Down start with value 00 -> DONE on next cycle, no tick needed.
//     start_pause -> PAUSE; if tick coincides, count step applied first.
//   - PAUSE: count and prescaler value frozen; start_pause -> RUN, prescaler
//     resumes from frozen value (no lost/extra partial period).
//   - DONE: count held at 99/00; ticks and start_pause ignored.
//   - clear in any state -> IDLE next edge; priority over start_pause and tick.
//   - Count updates visible 1 cycle after tick; outputs never leave 0..9 range.
//   - up_down changes outside IDLE have no effect until next start.
//   - running/done registered, mutually exclusive; both 0 in IDLE/PAUSE.
//   - Reset asserted mid-run: immediate return to reset values.
// STRUCTURE
//   - Shared package bcd_timer_pkg: state encodings S_IDLE/S_RUN/S_PAUSE/S_DONE
//     (2-bit), BCD_MAX=4'd9, BCD_MIN=4'd0.
//   - Sub-module tick_gen #(TICK_DIV): inputs en, clr; output tick; counter width
//     $clog2(TICK_DIV); holds value when en=0; clr has priority.
//   - Top: FSM, BCD up/down digit chain with carry/borrow, preset clamp.
// TESTING (TICK_DIV=4)
//   1 Reset: rst_n low mid-run -> tens/digits=0/0, running=0, done=0 immediately.
//   2 Up: up_down=1, start pulse -> after 10 ticks (40 cyc) 1/0; after 99 ticks
//     9/9, done=1, running=0; 20 more cycles -> still 9/9.
//   3 Down: preset 2/5, up_down=0 -> IDLE shows 2/5; start -> 2/4 after 4 cyc,
//     1/9 after 24 cyc-equivalent ticks (6 ticks); 25 ticks -> 0/0, done=1.
//   4 Pause: up, start, 3 ticks (0/3), pause 2 cyc into period, hold 30 cyc ->
//     0/3; resume -> 0/4 exactly 2 cycles later.
//   5 Clear collision: in RUN, clear+start_pause+tick same cycle -> IDLE, 0/0,
//     running=0; in DONE, start_pause alone ignored.
//   6 Edge presets: preset C/F, down -> shows 9/9; preset 0/0, down, start ->
//     done=1 next cycle, count 0/0.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch/countdown engine.
package bcd_timer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   // Out-of-range preset nibbles saturate to the largest legal digit.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage

// File: rtl/bcd_timer_core_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles; value frozen while disabled.
module tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bcd_timer_core.sv
// Two-digit BCD up/down timer: control FSM, digit chain with carry/borrow, preset clamp.
module bcd_timer_core #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_pause,
   input  logic       clear,
   input  logic       up_down,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_digits,
   output logic [3:0] tens_BCD,
   output logic [3:0] digits_BCD,
   output logic       running,
   output logic       done
);

   import bcd_timer_pkg::*;

   state_e     state_q, state_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] digits_q, digits_d;
   logic       dir_q, dir_d;
   logic       running_q, done_q;

   logic       tick;
   logic [3:0] idle_tens, idle_digits;
   logic [3:0] step_tens, step_digits;
   logic       step_terminal;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_q == S_RUN),
      .clr   ((state_q == S_IDLE) || clear),
      .tick  (tick)
   );

   assign idle_tens   = up_down ? BCD_MIN : bcd_clamp(preset_tens);
   assign idle_digits = up_down ? BCD_MIN : bcd_clamp(preset_digits);

   // Value after one count step in the latched direction; saturating so the
   // digits stay in 0..9 even if the chain were ever stepped past a terminal.
   always_comb begin
      step_tens   = tens_q;
      step_digits = digits_q;
      if (dir_q) begin
         if (digits_q >= BCD_MAX) begin
            step_digits = BCD_MIN;
            step_tens   = (tens_q >= BCD_MAX) ? BCD_MAX : tens_q + 4'd1;
         end else begin
            step_digits = digits_q + 4'd1;
         end
      end else begin
         if (digits_q == BCD_MIN) begin
            step_digits = BCD_MAX;
            step_tens   = (tens_q == BCD_MIN) ? BCD_MIN : tens_q - 4'd1;
         end else begin
            step_digits = digits_q - 4'd1;
         end
      end
      step_terminal = dir_q ? ((step_tens == BCD_MAX) && (step_digits == BCD_MAX))
                            : ((step_tens == BCD_MIN) && (step_digits == BCD_MIN));
   end

   always_comb begin
      state_d  = state_q;
      tens_d   = tens_q;
      digits_d = digits_q;
      dir_d    = dir_q;
      if (clear) begin
         state_d  = S_IDLE;
         tens_d   = idle_tens;
         digits_d = idle_digits;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               tens_d   = idle_tens;
               digits_d = idle_digits;
               if (start_pause) begin
                  state_d = S_RUN;
                  dir_d   = up_down;
               end
            end
            S_RUN: begin
               if (!dir_q && (tens_q == BCD_MIN) && (digits_q == BCD_MIN)) begin
                  // Countdown started from 00: nothing to count.
                  state_d = S_DONE;
               end else begin
                  if (tick) begin
                     tens_d   = step_tens;
                     digits_d = step_digits;
                  end
                  if (tick && step_terminal) begin
                     state_d = S_DONE;
                  end else if (start_pause) begin
                     state_d = S_PAUSE;
                  end
               end
            end
            S_PAUSE: begin
               if (start_pause) begin
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         tens_q    <= BCD_MIN;
         digits_q  <= BCD_MIN;
         dir_q     <= 1'b1;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tens_q    <= tens_d;
         digits_q  <= digits_d;
         dir_q     <= dir_d;
         running_q <= (state_d == S_RUN);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign tens_BCD   = tens_q;
   assign digits_BCD = digits_q;
   assign running    = running_q;
   assign done       = done_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Directed bench for bcd_timer_core with TICK_DIV=4; expectations queued, then checked.
module tb_bcd_timer_core;

   logic       clk;
   logic       rst_n;
   logic       start_pause;
   logic       clear;
   logic       up_down;
   logic [3:0] preset_tens;
   logic [3:0] preset_digits;
   logic [3:0] tens_BCD;
   logic [3:0] digits_BCD;
   logic       running;
   logic       done;

   typedef struct {
      string      tag;
      logic [3:0] t;
      logic [3:0] d;
      logic       r;
      logic       dn;
   } exp_t;

   exp_t sb[$];
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   bcd_timer_core #(
      .TICK_DIV (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_pause   (start_pause),
      .clear         (clear),
      .up_down       (up_down),
      .preset_tens   (preset_tens),
      .preset_digits (preset_digits),
      .tens_BCD      (tens_BCD),
      .digits_BCD    (digits_BCD),
      .running       (running),
      .done          (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_pause = 1'b1;
      step(1);
      start_pause = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic push(input string tag, input logic [3:0] t, input logic [3:0] d,
                       input logic r, input logic dn);
      exp_t e;
      e.tag = tag;
      e.t   = t;
      e.d   = d;
      e.r   = r;
      e.dn  = dn;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t       e;
      logic [9:0] obs, expv;
      total_cnt++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard: no expectation queued");
      end else begin
         e    = sb.pop_front();
         obs  = {tens_BCD, digits_BCD, running, done};
         expv = {e.t, e.d, e.r, e.dn};
         assert (obs === expv) pass_cnt++;
         else $error("FAIL %s: got t=%0d d=%0d run=%0b done=%0b, want t=%0d d=%0d run=%0b done=%0b",
                     e.tag, tens_BCD, digits_BCD, running, done, e.t, e.d, e.r, e.dn);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      start_pause   = 1'b0;
      clear         = 1'b0;
      up_down       = 1'b1;
      preset_tens   = 4'd0;
      preset_digits = 4'd0;
      #12;
      push("reset_state", 4'd0, 4'd0, 1'b0, 1'b0);
      pop_check();
      rst_n = 1'b1;
      step(1);

      // Reset asserted mid-run
      push("mid_run", 4'd0, 4'd2, 1'b1, 1'b0);
      pulse_start();
      step(9);
      pop_check();
      push("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      pop_check();
      #1;
      rst_n = 1'b1;
      step(1);

      // Count up to 99
      up_down = 1'b1;
      push("up_start", 4'd0, 4'd0, 1'b1, 1'b0);
      pulse_start();
      pop_check();
      push("up_10_ticks", 4'd1, 4'd0, 1'b1, 1'b0);
      step(40);
      pop_check();
      push("up_98", 4'd9, 4'd8, 1'b1, 1'b0);
      step(355);
      pop_check();
      push("up_99_done", 4'd9, 4'd9, 1'b0, 1'b1);
      step(1);
      pop_check();
      push("up_hold", 4'd9, 4'd9, 1'b0, 1'b1);
      step(20);
      pop_check();
      push("clear_from_done", 4'd0, 4'd0, 1'b0, 1'b0);
      do_clear();
      pop_check();

      // Count down from preset 25
      up_down       = 1'b0;
      preset_tens   = 4'd2;
      preset_digits = 4'd5;
      push("down_idle", 4'd2, 4'd5, 1'b0, 1'b0);
      step(1);
      pop_check();
      push("down_start", 4'd2, 4'd5, 1'b1, 1'b0);
      pulse_start();
      pop_check();
      push("down_1_tick", 4'd2, 4'd4, 1'b1, 1'b0);
      step(4);
      pop_check();
      push("down_borrow", 4'd1, 4'd9, 1'b1, 1'b0);
      step(20);
      pop_check();
      push("down_01", 4'd0, 4'd1, 1'b1, 1'b0);
      step(75);
      pop_check();
      push("down_00_done", 4'd0, 4'd0, 1'b0, 1'b1);
      step(1);
      pop_check();
      do_clear();

      // Pause two cycles into a period, then resume
      up_down = 1'b1;
      step(1);
      pulse_start();
      push("pause_pre", 4'd0, 4'd3, 1'b1, 1'b0);
      step(12);
      pop_check();
      step(1);
      push("pause_enter", 4'd0, 4'd3, 1'b0, 1'b0);
      pulse_start();
      pop_check();
      push("pause_hold", 4'd0, 4'd3, 1'b0, 1'b0);
      step(30);
      pop_check();
      push("resume", 4'd0, 4'd3, 1'b1, 1'b0);
      pulse_start();
      pop_check();
      push("resume_plus1", 4'd0, 4'd3, 1'b1, 1'b0);
      step(1);
      pop_check();
      push("resume_plus2", 4'd0, 4'd4, 1'b1, 1'b0);
      step(1);
      pop_check();
      do_clear();

      // up_down changes while running are ignored
      up_down = 1'b1;
      step(1);
      pulse_start();
      step(3);
      up_down = 1'b0;
      push("dir_latched", 4'd0, 4'd2, 1'b1, 1'b0);
      step(5);
      pop_check();
      do_clear();

      // clear + start_pause + tick in the same cycle
      up_down = 1'b1;
      step(1);
      pulse_start();
      step(3);
      clear       = 1'b1;
      start_pause = 1'b1;
      push("clear_collision", 4'd0, 4'd0, 1'b0, 1'b0);
      step(1);
      clear       = 1'b0;
      start_pause = 1'b0;
      pop_check();
      push("idle_stays", 4'd0, 4'd0, 1'b0, 1'b0);
      step(8);
      pop_check();

      // Down start from 00, then start_pause in DONE is ignored
      up_down       = 1'b0;
      preset_tens   = 4'd0;
      preset_digits = 4'd0;
      step(1);
      push("zero_start", 4'd0, 4'd0, 1'b1, 1'b0);
      pulse_start();
      pop_check();
      push("zero_done", 4'd0, 4'd0, 1'b0, 1'b1);
      step(1);
      pop_check();
      push("done_ignores_start", 4'd0, 4'd0, 1'b0, 1'b1);
      pulse_start();
      step(10);
      pop_check();
      do_clear();

      // Out-of-range presets clamp to 9
      preset_tens   = 4'hC;
      preset_digits = 4'hF;
      push("clamp_idle", 4'd9, 4'd9, 1'b0, 1'b0);
      step(1);
      pop_check();
      pulse_start();
      push("clamp_count", 4'd9, 4'd8, 1'b1, 1'b0);
      step(4);
      pop_check();
      do_clear();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
